md5_padder: RTL

- Upstream stage of the MD5 round core.
- Accepts a message as a byte stream (valid/ready) and forms 512-bit blocks as 16 little-endian 32-bit words.
- Applies MD5 padding: 0x80 marker, zero fill, and the 64-bit little-endian bit length.
- Hands each block to the core over a valid/ready handshake and flags the final block of the message.

---
 rtl/md5_padder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/md5_padder.sv
// MD5 padding front end: packs a byte stream into 512-bit little-endian
// blocks, appends the 0x80 marker, zero fill and the 64-bit bit length,
// and offers each block to the round core over valid/ready.
module md5_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   in_data_i,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  input  logic         in_empty_i,
  output logic         in_ready_o,
  output logic [511:0] blk_o,
  output logic         blk_valid_o,
  output logic         blk_last_o,
  input  logic         blk_ready_i
);

  typedef enum logic [2:0] {FILL, PAD, LEN, OUT, OUT2} state_t;

  state_t             state, state_nx;
  logic [5:0]         ptr;
  logic               carry;      // pointer reached 64 on the final byte
  logic [LEN_W-1:0]   count;
  logic [511:0]       blk;
  logic               last;
  logic               extra;      // a second padding block is still owed
  logic               run;        // low until the first edge after reset
  logic [63:0]        bitlen;
  logic               take;
  logic               empty_go;
  logic               hs;

  assign in_ready_o  = run && (state == FILL);
  assign blk_valid_o = (state == OUT) || (state == OUT2);
  assign blk_o       = blk;
  assign blk_last_o  = last;

  assign take     = in_valid_i && in_ready_o;
  assign empty_go = in_ready_o && in_empty_i && !take && (ptr == 6'd0) && !carry && (count == '0);
  assign hs       = blk_valid_o && blk_ready_i;
  assign bitlen   = 64'({count, 3'b000});

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= FILL;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: begin
        if (take && in_last_i)            state_nx = PAD;
        else if (take && ptr == 6'd63)    state_nx = OUT;
        else if (empty_go)                state_nx = PAD;
      end
      PAD:  state_nx = (carry || ptr >= 6'd56) ? OUT : LEN;
      LEN:  state_nx = extra ? OUT2 : OUT;
      OUT:  if (hs) state_nx = extra ? LEN : FILL;
      OUT2: if (hs) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Block assembly, pointer/count bookkeeping and padding
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr   <= '0;
      carry <= 1'b0;
      count <= '0;
      blk   <= '0;
      last  <= 1'b0;
      extra <= 1'b0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        FILL: begin
          if (take) begin
            blk[{ptr, 3'b000} +: 8] <= in_data_i;
            count <= count + LEN_W'(1);
            if (in_last_i) {carry, ptr} <= {1'b0, ptr} + 7'd1;
            else           ptr <= ptr + 6'd1;
          end
        end
        PAD: begin
          // Zeroing every byte above p is harmless when p<=55: LEN
          // overwrites bytes 56..63 on the next cycle.
          if (!carry) begin
            for (int unsigned i = 0; i < 64; i++) begin
              if (i == 32'(ptr))     blk[i*8 +: 8] <= 8'h80;
              else if (i > 32'(ptr)) blk[i*8 +: 8] <= 8'h00;
            end
          end
          extra <= carry || (ptr >= 6'd56);
          last  <= 1'b0;
        end
        LEN: begin
          blk[511:448] <= bitlen;
          last         <= 1'b1;
        end
        OUT: begin
          if (hs) begin
            if (extra) begin
              blk[447:0] <= '0;
              if (carry) blk[7:0] <= 8'h80;
            end else begin
              if (last) count <= '0;
              ptr   <= '0;
              carry <= 1'b0;
              last  <= 1'b0;
            end
          end
        end
        OUT2: begin
          if (hs) begin
            count <= '0;
            ptr   <= '0;
            carry <= 1'b0;
            last  <= 1'b0;
            extra <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
